multi_channel_fifo: RTL and testbench
=====================================

Name: multi_channel_fifo

Overview:
Parametrised successor to the single-queue circular buffer. It holds NUM_CH independent circular queues, for example one per warp or issue slot, in one block. Each cycle it accepts at most one push and one pop, and each is steered by a channel index. It adds per-channel occupancy counts, full/empty flags, registered pop data with a valid strobe, a combinational head peek, and sticky overflow/underflow error flags in place of in-band error data.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 16, entries per channel; power of two, >= 2
NUM_CH, 4, number of independent queues; >= 1
CH_W, $clog2(NUM_CH) (min 1), derived localparam: channel index width
CNT_W, $clog2(DEPTH+1), derived localparam: occupancy count width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; synchronous, active-high
push_valid  input  1  push request this cycle
push_ch  input  CH_W  target channel for push
push_data  input  WIDTH  data to enqueue
push_ready  output  1  combinational: !full[push_ch]
pop_valid  input  1  pop request this cycle
pop_ch  input  CH_W  source channel for pop
pop_ready  output  1  combinational: !empty[pop_ch]
pop_data  output  WIDTH  registered dequeued word
pop_data_valid  output  1  one-cycle strobe, pop_data updated
peek_ch  input  CH_W  channel to peek
peek_data  output  WIDTH  combinational head entry of peek_ch; 0 when that channel is empty
peek_valid  output  1  !empty[peek_ch]
full  output  NUM_CH  per-channel full flags
empty  output  NUM_CH  per-channel empty flags
count  output  NUM_CH*CNT_W  per-channel occupancy; channel i at bits [i*CNT_W +: CNT_W]
err_clear  input  1  clears sticky error flags
overflow_err  output  1  sticky: push was rejected
underflow_err  output  1  sticky: pop was rejected

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All head/tail pointers = 0 and all counts = 0.
  - empty = all 1s, full = all 0s.
  - pop_data = 0, pop_data_valid = 0, overflow_err = 0, underflow_err = 0.
  - Storage is not cleared.
  - A reset asserted mid-operation discards all queued contents. Any push or pop in that same cycle is ignored.
- full[i] = (count[i]==DEPTH); empty[i] = (count[i]==0). Both are derived from registered counts.
- Push acceptance:
  - A push is accepted when push_valid && !full[push_ch], judged on start-of-cycle state.
  - On accept: mem[push_ch][tail] <= push_data, tail increments modulo DEPTH (DEPTH-1 wraps to 0), count increments.
  - On reject: state is unchanged and overflow_err <= 1.
- Pop acceptance:
  - A pop is accepted when pop_valid && !empty[pop_ch], judged on start-of-cycle state.
  - On accept: pop_data <= mem[pop_ch][head], pop_data_valid <= 1 next cycle, head increments modulo DEPTH, count decrements. Latency is 1 cycle.
  - On reject: pop_data holds its value, pop_data_valid <= 0, underflow_err <= 1.
  - A cycle without an accepted pop drives pop_data_valid = 0 and holds pop_data.
- Simultaneous push and pop, different channels: each is evaluated independently; both may be accepted.
- Simultaneous push and pop, same channel, with 0 < count < DEPTH:
  - Both are accepted and count is unchanged.
  - The pop returns the old head, never the word being pushed.
- Same channel, empty: the push is accepted and the pop is rejected (no bypass). underflow_err is set and count becomes 1.
- Same channel, full: the pop is accepted and the push is rejected, based on start-of-cycle state. overflow_err is set and count becomes DEPTH-1.
- Sticky errors:
  - err_clear=1 clears both flags.
  - If a new error event occurs in the same cycle as err_clear, the flag is set (set wins).
- peek_data and peek_valid are purely combinational from current state. They do not reflect any same-cycle push.
- Out-of-range channel index (NUM_CH not a power of two, index >= NUM_CH):
  - The request is rejected and flagged like full/empty: overflow_err for a push, underflow_err for a pop.
  - push_ready, pop_ready and peek_valid read 0 for such an index.

Test Plan:
- Reset, then push 0xA0..0xA3 to ch1 and pop ch1 four times -> pop_data 0xA0, 0xA1, 0xA2, 0xA3, each with pop_data_valid one cycle after its pop. Afterwards count[1]=0 and empty[1]=1.
- Push 16 words to ch2 (DEPTH=16), then push a 17th -> full[2]=1, push_ready=0 with push_ch=2, overflow_err=1, count[2] stays 16. Then pop 16 -> original order; pointers have wrapped.
- Push ch0 and pop ch3 in the same cycle with ch3 holding 0x55 -> both accepted, pop_data=0x55, count[0]=1, count[3]=0.
- Same-channel push and pop on empty ch1 with push_data 0x77 -> pop rejected, underflow_err=1, pop_data_valid=0, count[1]=1, peek_data=0x77 with peek_ch=1.
- Same-channel push and pop on full ch2 -> pop accepted returning head, push rejected, overflow_err=1, count[2]=15. Then assert err_clear alone -> both errors 0.
- Fill ch0 with 5 words, assert rst for one cycle together with a push to ch0 -> all counts 0, empty all 1s, pop_data_valid=0, errors 0.

Source files
------------

// File: rtl/multi_channel_fifo.sv
// -----------------------------------------------------------------------------
// multi_channel_fifo
//
// NUM_CH independent circular queues that share one storage block. At most
// one push and one pop are accepted per cycle. Each is steered to a queue by
// its own channel index. Pop data is registered and qualified by a one-cycle
// valid strobe. A combinational peek port exposes the head of any queue.
// Rejected requests raise sticky error flags, which err_clear clears.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset (control state only; the
//                   storage array is never cleared)
//   push_valid      push request this cycle
//   push_ch         target queue of the push
//   push_data       word to enqueue
//   push_ready      target queue exists and is not full (combinational)
//   pop_valid       pop request this cycle
//   pop_ch          source queue of the pop
//   pop_ready       source queue exists and is not empty (combinational)
//   pop_data        registered dequeued word (held when no pop is accepted)
//   pop_data_valid  one-cycle strobe: pop_data was updated by the last edge
//   peek_ch         queue whose head is shown on peek_data
//   peek_data       head word of peek_ch, 0 when that queue is empty
//   peek_valid      peek_ch exists and is not empty
//   full / empty    per-queue flags derived from registered counts
//   count           per-queue occupancy, queue i at [i*CNT_W +: CNT_W]
//   err_clear       clears overflow_err / underflow_err (a new error wins)
//   overflow_err    sticky: a push was rejected
//   underflow_err   sticky: a pop was rejected
// -----------------------------------------------------------------------------
module multi_channel_fifo #(
    parameter int  WIDTH  = 32,
    parameter int  DEPTH  = 16,
    parameter int  NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    push_valid,
    input  logic [CH_W-1:0]         push_ch,
    input  logic [WIDTH-1:0]        push_data,
    output logic                    push_ready,

    input  logic                    pop_valid,
    input  logic [CH_W-1:0]         pop_ch,
    output logic                    pop_ready,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    pop_data_valid,

    input  logic [CH_W-1:0]         peek_ch,
    output logic [WIDTH-1:0]        peek_data,
    output logic                    peek_valid,

    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       empty,
    output logic [NUM_CH*CNT_W-1:0] count,

    input  logic                    err_clear,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);

    // One past the highest legal channel index, at index width + 1 so the
    // comparison still works when NUM_CH is an exact power of two.
    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(NUM_CH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q  [NUM_CH][DEPTH];
    logic [PTR_W-1:0] head_q [NUM_CH];
    logic [PTR_W-1:0] tail_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q  [NUM_CH];
    logic [CNT_W-1:0] cnt_d  [NUM_CH];

    logic [WIDTH-1:0] pop_data_q;
    logic [WIDTH-1:0] pop_data_d;
    logic             pop_vld_q;
    logic             pop_vld_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             udf_q;
    logic             udf_d;

    // -------------------------------------------------------------------------
    // Channel index qualification
    // -------------------------------------------------------------------------
    // An index beyond NUM_CH-1 is treated as a queue that is both full and
    // empty. The *_idx copies are forced to 0 in that case, so that array
    // reads never go out of bounds. The *_ok terms mask any result.
    logic            push_ch_ok;
    logic            pop_ch_ok;
    logic            peek_ch_ok;
    logic [CH_W-1:0] push_idx;
    logic [CH_W-1:0] pop_idx;
    logic [CH_W-1:0] peek_idx;

    always_comb begin
        push_ch_ok = ({1'b0, push_ch} < CH_LIM);
        pop_ch_ok  = ({1'b0, pop_ch}  < CH_LIM);
        peek_ch_ok = ({1'b0, peek_ch} < CH_LIM);
        push_idx   = push_ch_ok ? push_ch : '0;
        pop_idx    = pop_ch_ok  ? pop_ch  : '0;
        peek_idx   = peek_ch_ok ? peek_ch : '0;
    end

    // -------------------------------------------------------------------------
    // Status flags and packed count output
    // -------------------------------------------------------------------------
    always_comb begin
        full  = '0;
        empty = '0;
        count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]                    = (cnt_q[i] == CNT_FULL);
            empty[i]                   = (cnt_q[i] == '0);
            count[i*CNT_W +: CNT_W]    = cnt_q[i];
        end
    end

    // -------------------------------------------------------------------------
    // Acceptance (judged purely on start-of-cycle state)
    // -------------------------------------------------------------------------
    logic push_acc;
    logic pop_acc;

    always_comb begin
        push_ready = push_ch_ok && !full[push_idx];
        pop_ready  = pop_ch_ok  && !empty[pop_idx];
        push_acc   = push_valid && push_ready;
        pop_acc    = pop_valid  && pop_ready;
    end

    // -------------------------------------------------------------------------
    // Head peek: the head of the selected queue. This path does not bypass
    // a push made in the same cycle, so an empty queue shows 0.
    // -------------------------------------------------------------------------
    always_comb begin
        peek_valid = peek_ch_ok && !empty[peek_idx];
        peek_data  = '0;
        if (peek_valid) begin
            peek_data = mem_q[peek_idx][head_q[peek_idx]];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: occupancy, pop output register, sticky errors
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push_acc && (push_idx == CH_W'(i)) && !(pop_acc && (pop_idx == CH_W'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (pop_acc && (pop_idx == CH_W'(i)) && !(push_acc && (push_idx == CH_W'(i)))) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end

        pop_data_d = pop_data_q;
        pop_vld_d  = 1'b0;
        if (pop_acc) begin
            pop_data_d = mem_q[pop_idx][head_q[pop_idx]];
            pop_vld_d  = 1'b1;
        end

        // The clear is applied first, so an error in the same cycle wins.
        ovf_d = err_clear ? 1'b0 : ovf_q;
        udf_d = err_clear ? 1'b0 : udf_q;
        if (push_valid && !push_acc) begin
            ovf_d = 1'b1;
        end
        if (pop_valid && !pop_acc) begin
            udf_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            pop_data_q <= '0;
            pop_vld_q  <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                // DEPTH is a power of two, so natural pointer overflow gives
                // the modulo-DEPTH wrap.
                if (push_acc && (push_idx == CH_W'(i))) begin
                    tail_q[i] <= tail_q[i] + PTR_W'(1);
                end
                if (pop_acc && (pop_idx == CH_W'(i))) begin
                    head_q[i] <= head_q[i] + PTR_W'(1);
                end
            end
            pop_data_q <= pop_data_d;
            pop_vld_q  <= pop_vld_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage: no reset. A write in a reset cycle is suppressed, so the
    // discarded push cannot land in the array.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            mem_q[push_idx][tail_q[push_idx]] <= push_data;
        end
    end

    assign pop_data       = pop_data_q;
    assign pop_data_valid = pop_vld_q;
    assign overflow_err   = ovf_q;
    assign underflow_err  = udf_q;

endmodule

// File: tb/tb_multi_channel_fifo.sv
module tb_multi_channel_fifo;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 16;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 5;

    logic                    clk;
    logic                    rst;
    logic                    push_valid;
    logic [CH_W-1:0]         push_ch;
    logic [WIDTH-1:0]        push_data;
    logic                    push_ready;
    logic                    pop_valid;
    logic [CH_W-1:0]         pop_ch;
    logic                    pop_ready;
    logic [WIDTH-1:0]        pop_data;
    logic                    pop_data_valid;
    logic [CH_W-1:0]         peek_ch;
    logic [WIDTH-1:0]        peek_data;
    logic                    peek_valid;
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH*CNT_W-1:0] count;
    logic                    err_clear;
    logic                    overflow_err;
    logic                    underflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference contents of each queue, and the words expected on pop_data
    // in order.
    logic [WIDTH-1:0] mq [NUM_CH][$];
    logic [WIDTH-1:0] sb [$];

    multi_channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
        .clk           (clk),
        .rst           (rst),
        .push_valid    (push_valid),
        .push_ch       (push_ch),
        .push_data     (push_data),
        .push_ready    (push_ready),
        .pop_valid     (pop_valid),
        .pop_ch        (pop_ch),
        .pop_ready     (pop_ready),
        .pop_data      (pop_data),
        .pop_data_valid(pop_data_valid),
        .peek_ch       (peek_ch),
        .peek_data     (peek_data),
        .peek_valid    (peek_valid),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .err_clear     (err_clear),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cnt_of(input int ch);
        return int'(count[ch*CNT_W +: CNT_W]);
    endfunction

    // Scoreboard monitor: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (pop_data_valid === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: pop_data_valid=1 data=%h, none expected", pop_data);
            end else begin
                logic [WIDTH-1:0] exp_w;
                exp_w = sb.pop_front();
                if (pop_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h expected %h", pop_data, exp_w);
                end
            end
        end
    end

    // Drive one cycle of stimulus and update the reference model using
    // start-of-cycle occupancy.
    task automatic do_cycle(input logic pv, input int pc, input logic [WIDTH-1:0] pd,
                            input logic qv, input int qc, input logic ec);
        bit push_ok;
        bit pop_ok;
        push_valid = pv;
        push_ch    = CH_W'(pc);
        push_data  = pd;
        pop_valid  = qv;
        pop_ch     = CH_W'(qc);
        err_clear  = ec;
        push_ok = pv && (mq[pc].size() < DEPTH);
        pop_ok  = qv && (mq[qc].size() > 0);
        if (pop_ok)  sb.push_back(mq[qc].pop_front());
        if (push_ok) mq[pc].push_back(pd);
        @(posedge clk); #1;
        push_valid = 1'b0;
        pop_valid  = 1'b0;
        err_clear  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (empty !== 4'hF) begin n_fail++; $display("FAIL reset_empty: got %h expected f", empty); end
        n_tests++; if (full !== 4'h0) begin n_fail++; $display("FAIL reset_full: got %h expected 0", full); end
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", count); end
        n_tests++; if (pop_data_valid !== 1'b0 || pop_data !== '0) begin n_fail++; $display("FAIL reset_pop: valid=%b data=%h expected 0/0", pop_data_valid, pop_data); end
        n_tests++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: ovf=%b udf=%b expected 0/0", overflow_err, underflow_err); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1, 32'hA0 + i, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 0, '0, 1'b1, 1, 1'b0);
            n_tests++;
            if (pop_data_valid !== 1'b1 || pop_data !== 32'hA0 + i) begin
                n_fail++; $display("FAIL basic_pop%0d: valid=%b data=%h expected 1/%h", i, pop_data_valid, pop_data, 32'hA0 + i);
            end
        end
        do_cycle(1'b0, 0, '0, 1'b0, 0, 1'b0);
        n_tests++; if (pop_data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_strobe: got %b expected 0", pop_data_valid); end
        n_tests++; if (cnt_of(1) != 0 || empty[1] !== 1'b1) begin n_fail++; $display("FAIL basic_drained: count=%0d empty=%b expected 0/1", cnt_of(1), empty[1]); end
        @(negedge clk); #1;
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL basic_sb: %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 2, 32'h200 + i, 1'b0, 0, 1'b0);
        n_tests++; if (full[2] !== 1'b1 || push_ready !== 1'b0) begin n_fail++; $display("FAIL full_flag: full=%b ready=%b expected 1/0", full[2], push_ready); end
        do_cycle(1'b1, 2, 32'h2FF, 1'b0, 0, 1'b0);
        n_tests++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL full_ovf: got %b expected 1", overflow_err); end
        n_tests++; if (cnt_of(2) != DEPTH) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", cnt_of(2), DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 0, '0, 1'b1, 2, 1'b0);
            n_tests++;
            if (pop_data !== 32'h200 + i) begin n_fail++; $display("FAIL full_order%0d: got %h expected %h", i, pop_data, 32'h200 + i); end
        end
        n_tests++; if (empty[2] !== 1'b1 || full[2] !== 1'b0) begin n_fail++; $display("FAIL full_drained: empty=%b full=%b expected 1/0", empty[2], full[2]); end
        // Pointers have wrapped to 0; run a few more words through.
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 2, 32'h2A0 + i, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 0, '0, 1'b1, 2, 1'b0);
        do_cycle(1'b0, 0, '0, 1'b0, 0, 1'b1);
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_sb: %0d outstanding expected 0", sb.size()); end
        n_tests++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL wrap_clear: got %b expected 0", overflow_err); end
    endtask

    task automatic test_diff_channels();
        do_cycle(1'b1, 3, 32'h55, 1'b0, 0, 1'b0);
        do_cycle(1'b1, 0, 32'h11, 1'b1, 3, 1'b0);
        n_tests++; if (pop_data_valid !== 1'b1 || pop_data !== 32'h55) begin n_fail++; $display("FAIL diff_pop: valid=%b data=%h expected 1/55", pop_data_valid, pop_data); end
        n_tests++; if (cnt_of(0) != 1 || cnt_of(3) != 0) begin n_fail++; $display("FAIL diff_count: ch0=%0d ch3=%0d expected 1/0", cnt_of(0), cnt_of(3)); end
        n_tests++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL diff_err: ovf=%b udf=%b expected 0/0", overflow_err, underflow_err); end
    endtask

    task automatic test_same_empty();
        peek_ch = 2'd1;
        #1;
        n_tests++; if (peek_valid !== 1'b0 || peek_data !== '0) begin n_fail++; $display("FAIL peek_empty: valid=%b data=%h expected 0/0", peek_valid, peek_data); end
        do_cycle(1'b1, 1, 32'h77, 1'b1, 1, 1'b0);
        n_tests++; if (underflow_err !== 1'b1 || pop_data_valid !== 1'b0) begin n_fail++; $display("FAIL same_empty: udf=%b valid=%b expected 1/0", underflow_err, pop_data_valid); end
        n_tests++; if (pop_data !== 32'h55) begin n_fail++; $display("FAIL same_empty_hold: got %h expected 55", pop_data); end
        n_tests++; if (cnt_of(1) != 1) begin n_fail++; $display("FAIL same_empty_count: got %0d expected 1", cnt_of(1)); end
        n_tests++; if (peek_valid !== 1'b1 || peek_data !== 32'h77) begin n_fail++; $display("FAIL peek_head: valid=%b data=%h expected 1/77", peek_valid, peek_data); end
    endtask

    task automatic test_same_full();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 2, 32'h300 + i, 1'b0, 0, 1'b0);
        do_cycle(1'b1, 2, 32'hDEAD, 1'b1, 2, 1'b0);
        n_tests++; if (pop_data_valid !== 1'b1 || pop_data !== 32'h300) begin n_fail++; $display("FAIL same_full_pop: valid=%b data=%h expected 1/300", pop_data_valid, pop_data); end
        n_tests++; if (overflow_err !== 1'b1 || cnt_of(2) != DEPTH - 1) begin n_fail++; $display("FAIL same_full: ovf=%b count=%0d expected 1/%0d", overflow_err, cnt_of(2), DEPTH - 1); end
        do_cycle(1'b0, 0, '0, 1'b0, 0, 1'b1);
        n_tests++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: ovf=%b udf=%b expected 0/0", overflow_err, underflow_err); end
        // A rejected pop in the same cycle as err_clear leaves the flag set.
        do_cycle(1'b0, 0, '0, 1'b1, 3, 1'b1);
        n_tests++; if (underflow_err !== 1'b1 || overflow_err !== 1'b0) begin n_fail++; $display("FAIL set_wins: udf=%b ovf=%b expected 1/0", underflow_err, overflow_err); end
        @(negedge clk); #1;
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL same_full_sb: %0d outstanding expected 0", sb.size()); end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 0, 32'hC0 + i, 1'b0, 0, 1'b0);
        n_tests++; if (cnt_of(0) != 6) begin n_fail++; $display("FAIL flush_fill: got %0d expected 6", cnt_of(0)); end
        // Reset with a push and a pop in flight; both must be ignored.
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        sb.delete();
        rst        = 1'b1;
        push_valid = 1'b1; push_ch = 2'd0; push_data = 32'hBAD;
        pop_valid  = 1'b1; pop_ch  = 2'd2;
        @(posedge clk); #1;
        rst = 1'b0; push_valid = 1'b0; pop_valid = 1'b0;
        n_tests++; if (count !== '0 || empty !== 4'hF) begin n_fail++; $display("FAIL flush_state: count=%h empty=%h expected 0/f", count, empty); end
        n_tests++; if (pop_data_valid !== 1'b0 || pop_data !== '0) begin n_fail++; $display("FAIL flush_pop: valid=%b data=%h expected 0/0", pop_data_valid, pop_data); end
        n_tests++; if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin n_fail++; $display("FAIL flush_err: ovf=%b udf=%b expected 0/0", overflow_err, underflow_err); end
        do_cycle(1'b0, 0, '0, 1'b1, 0, 1'b0);
        n_tests++; if (pop_data_valid !== 1'b0 || underflow_err !== 1'b1) begin n_fail++; $display("FAIL flush_after: valid=%b udf=%b expected 0/1", pop_data_valid, underflow_err); end
        @(negedge clk); #1;
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL flush_sb: %0d outstanding expected 0", sb.size()); end
    endtask

    initial begin
        rst = 1'b1; push_valid = 1'b0; push_ch = '0; push_data = '0;
        pop_valid = 1'b0; pop_ch = '0; peek_ch = '0; err_clear = 1'b0;
        test_reset();
        test_basic();
        test_full_wrap();
        test_diff_channels();
        test_same_empty();
        test_same_full();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
